// File: rtl/bcd_down_cnt.sv
`default_nettype none
// ============================================================================
// Module   : bcd_down_cnt
// Brief    : Loadable packed-BCD countdown timer with start/pause/abort
//            control, one-cycle done pulse and optional auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_down_cnt #(
  parameter int place       = 4,
  parameter bit auto_reload = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [4*place-1:0]   load_val,
  input  logic                 start,
  input  logic                 pause,
  output logic [4*place-1:0]   q,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int W = 4 * place;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   reload_q, reload_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  // Per-digit BCD decrement with a ripple borrow, plus per-digit legality of load_val
  logic [place:0] borrow;
  logic [place-1:0] digit_bad;
  logic [W-1:0]   cnt_dec;

  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < place; gi++) begin : g_digit
      logic [3:0] cur;
      assign cur           = cnt_q[4*gi +: 4];
      assign digit_bad[gi] = (load_val[4*gi +: 4] > 4'd9);
      // A zero digit that receives a borrow wraps to 9 and keeps the borrow going
      assign cnt_dec[4*gi +: 4] = !borrow[gi]   ? cur :
                                  (cur == 4'd0) ? 4'd9 : (cur - 4'd1);
      assign borrow[gi+1] = borrow[gi] && (cur == 4'd0);
    end
  endgenerate

  logic load_ok;
  logic cnt_is_zero;
  logic cnt_is_one;

  assign load_ok     = (digit_bad == '0);
  assign cnt_is_zero = (cnt_q == '0);
  assign cnt_is_one  = (cnt_q == W'(1));

  // Next-state logic: load beats pause, pause beats start
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    err_d    = err_q;
    done_d   = 1'b0;

    if (load) begin
      // An illegal value leaves the count running state untouched; only err reports it
      if (load_ok) begin
        cnt_d    = load_val;
        reload_d = load_val;
        state_d  = ST_IDLE;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !cnt_is_zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (cnt_is_zero) begin
            // Only reachable with auto-reload: the cycle after the done pulse reloads
            cnt_d = reload_q;
            if (reload_q == '0) state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_dec;
            if (cnt_is_one) begin
              done_d = 1'b1;
              if (!auto_reload || (reload_q == '0)) state_d = ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (start) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign q    = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: doc/bcd_down_cnt.md
# bcd_down_cnt

Loadable multi-digit BCD countdown timer. It complements the BCD up-counter: it counts a packed-BCD value down to zero, one decrement per clock while running, and emits a one-cycle `done` pulse on reaching zero. Start, pause and abort controls are driven by a small state machine, and an optional auto-reload mode turns the block into a periodic BCD tick generator. It is used for display countdowns and programmable decimal timeouts.

## Interface
- `place`, default 4: number of BCD digits; `q` is 4*`place` bits wide, digit i at bits [4i+3:4i].
- `auto_reload`, default 0: when 1, the counter reloads the last loaded value after reaching zero and keeps running.
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `load`  input  1  load request; samples `load_val`.
- `load_val`  input  4*`place`  packed BCD start value.
- `start`  input  1  start a count from IDLE, or resume from HOLD.
- `pause`  input  1  freeze the count while in RUN.
- `q`  output  4*`place`  current packed BCD count (registered).
- `busy`  output  1  high when the state is RUN or HOLD (registered).
- `done`  output  1  one-cycle pulse when the count reaches zero (registered).
- `err`  output  1  sticky flag: the last load attempt contained a digit greater than 9.

## Operation
- States: IDLE, RUN, HOLD.
- Reset (asynchronous) values: state=IDLE, `q`=0, reload register=0, `busy`=0, `done`=0, `err`=0.
- Control priority per edge: `load` > `pause` > `start`.
- Load, legal in any state:
  - Every digit of `load_val` ≤ 9: `q` and the reload register take `load_val`, state becomes IDLE, `err` clears.
  - Any digit > 9: `q`, the reload register and the state are unchanged; `err` sets.
  - A load during RUN or HOLD aborts the count. No `done` is produced.
- IDLE:
  - `start` with `q` ≠ 0: go to RUN. `q` does not change on this edge.
  - `start` with `q` = 0: ignored.
- RUN, on each edge without `load` or `pause`, decrement `q` by 1 in BCD:
  - Digit 0 receives borrow-in 1.
  - A digit equal to 0 with borrow-in becomes 9 and passes the borrow on.
  - Otherwise the digit decrements and the borrow chain stops.
  - Only values 0–9 ever appear in any digit.
- Reaching zero in RUN (`q` = 1 before the edge):
  - `q` becomes 0 and `done` goes high for exactly one cycle.
  - `auto_reload`=0: state becomes IDLE.
  - `auto_reload`=1: state stays RUN. On the next edge `q` takes the reload value, so the period is reload+1 cycles.
  - If the reload value is 0, state becomes IDLE.
- RUN with `pause`: go to HOLD with no decrement on that edge.
- HOLD:
  - `q` holds.
  - `start` returns to RUN; decrementing resumes on the following edge.
  - `pause` in HOLD has no effect.
- `done` is never asserted except on a RUN decrement from 1 to 0.
- Simultaneous `pause` and `start` in RUN: `pause` wins.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Load: `q` and `err` update at the edge where `load` is sampled high.
- Start: `start` sampled high at edge n enters RUN at edge n. The first decrement happens at edge n+1.
- Count duration: for start value N (binary equivalent of the BCD value), `q` reaches 0 at edge n+N. `done` is high during the cycle after edge n+N, and `busy` drops at the same edge.
- Pause: `pause` sampled high at edge k means no decrement at edge k. `start` sampled high at edge m in HOLD means the next decrement is at edge m+1.
- Reset: asserting `rst_n` low at any point forces the reset values immediately, with no clock required. The first sampled edge after deassertion behaves as IDLE.

## Test plan
- Basic count:
  - Stimulus: with `place`=4, load 0x0003, then `start`.
  - Required: `q` steps 3,2,1,0 on successive edges; `done` is high one cycle, coincident with `q`=0; `busy` is 1 for three cycles and then 0.
- Borrow ripple:
  - Stimulus: load 0x1000, start.
  - Required: after the first decrement `q`=0x0999; after 1000 decrements `q`=0 with a single `done`.
- Invalid load:
  - Stimulus: load 0x0012, then load 0x00A5.
  - Required: `q` stays 0x0012 and `err`=1. A following load of 0x0007 clears `err`.
- Pause and resume:
  - Stimulus: load 0x0010, start, pulse `pause` after 3 decrements (`q`=0x0007), hold 5 cycles, then `start`.
  - Required: `q` stays 0x0007 through HOLD, then resumes 6,5,…; `done` occurs exactly 7 edges after the resume.
- Abort and zero-start:
  - Stimulus: load during RUN at `q`=0x0004 with value 0x0009; separately, `start` with `q`=0.
  - Required: the abort gives state IDLE, `q`=0x0009 and no `done`; the zero-start is ignored, with `busy`=0 and `done`=0.
- Auto-reload and reset:
  - Stimulus: with `auto_reload`=1, load 0x0002 and start; later assert `rst_n` low mid-count.
  - Required: `q` follows 1,0,2,1,0,2…; `done` is high each time `q`=0. On reset, `q`=0, `busy`=0 and `done`=0 immediately (asynchronously).
